version_info_tx: RTL and testbench

- Parametrised build-identification streamer: holds version number and BCD build timestamp as parameters, keeps a seconds-uptime counter, and on request emits a framed, checksummed byte packet over a valid/ready byte stream.
- Sits between the top-level build constants and the host link (UART/USB bridge), so the host can query firmware identity and uptime at runtime.

---
 rtl/version_info_tx.sv | 191 +++++++++++++++++++
 tb/tb_version_info_tx.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/version_info_tx.sv
// rtl/version_info_tx.sv - build identification and uptime frame streamer
//
// Purpose:
//   Streams one framed, checksummed identification packet per request:
//     SYNC_BYTE, LEN, VERSION_WORD (4 B), BUILD_STAMP (7 B),
//     uptime snapshot (UPTIME_BYTES B, MSB first), CHK.
//   LEN = 11 + UPTIME_BYTES, and CHK makes the byte sum LEN..CHK zero mod 256.
//   A free-running prescaler advances a saturating seconds counter.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   req         in   single-cycle frame request (one extra request is queued)
//   tx_data     out  stream byte
//   tx_valid    out  tx_data valid
//   tx_ready    in   sink accepts the byte when tx_valid && tx_ready
//   busy        out  frame in progress or request pending
//   done        out  one-cycle pulse after the checksum byte is accepted
//   uptime_sec  out  live seconds since reset (0 when UPTIME_BYTES = 0)

module version_info_tx #(
  parameter logic [31:0] VERSION_WORD = 32'h0000_0000,
  parameter logic [55:0] BUILD_STAMP  = 56'h0,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned UPTIME_BYTES = 4,
  parameter int unsigned CLK_HZ       = 100_000_000,
  localparam int unsigned UW = (UPTIME_BYTES == 0) ? 1 : 8 * UPTIME_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done,
  output logic [UW-1:0] uptime_sec
);

  // Bytes sent before the checksum: SYNC, LEN, version, stamp, uptime.
  localparam int unsigned NPAY      = 13 + UPTIME_BYTES;
  localparam int unsigned FW        = 8 * NPAY;
  localparam logic [7:0]  LEN_BYTE  = 8'(11 + UPTIME_BYTES);
  localparam logic [4:0]  LAST_IDX  = 5'(NPAY - 1);
  localparam logic [7:0]  SHAMT_TOP = 8'(8 * (NPAY - 1));
  localparam logic [103:0] HDR      = {SYNC_BYTE, LEN_BYTE, VERSION_WORD, BUILD_STAMP};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_CHK
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic       pending_q, pending_d;
  logic       done_q, done_d;
  logic       start;

  logic [FW-1:0] frame_w;
  logic [7:0]    shamt;
  logic [7:0]    cur_byte;

  // ---------------------------------------------------------------------
  // Uptime counter and frame snapshot
  // ---------------------------------------------------------------------
  if (UPTIME_BYTES > 0) begin : g_up
    localparam int unsigned PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q;
    logic [UW-1:0] up_q;
    logic [UW-1:0] snap_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        presc_q <= '0;
        up_q    <= '0;
        snap_q  <= '0;
      end else begin
        if (presc_q == PRESC_MAX) begin
          presc_q <= '0;
          // Saturate rather than wrap so a long-running board never
          // reports a small uptime.
          if (up_q != '1) begin
            up_q <= up_q + 1'b1;
          end
        end else begin
          presc_q <= presc_q + 1'b1;
        end
        // Snapshot taken in the IDLE cycle that launches a frame, so
        // later ticks never disturb the bytes being sent.
        if (start) begin
          snap_q <= up_q;
        end
      end
    end

    assign uptime_sec = up_q;
    assign frame_w    = {HDR, snap_q};
  end else begin : g_noup
    assign uptime_sec = '0;
    assign frame_w    = HDR;
  end

  // Byte idx of the frame, counted from the MSB end of frame_w.
  always_comb begin
    shamt    = SHAMT_TOP - {idx_q, 3'b000};
    cur_byte = 8'(frame_w >> shamt);
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      sum_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    start     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;

    // A request arriving mid-frame is remembered once; extras are dropped.
    if (state_q != S_IDLE && req) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req || pending_q) begin
          start     = 1'b1;
          pending_d = 1'b0;
          idx_d     = '0;
          sum_d     = '0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (tx_ready) begin
          idx_d = idx_q + 5'd1;
          // SYNC (index 0) is excluded from the checksum.
          if (idx_q != 5'd0) begin
            sum_d = sum_q + cur_byte;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_CHK;
          end
        end
      end

      S_CHK: begin
        tx_valid = 1'b1;
        tx_data  = 8'h00 - sum_q;
        if (tx_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE) || pending_q;
  assign done = done_q;

endmodule

// File: tb/tb_version_info_tx.sv
// tb/tb_version_info_tx.sv - scoreboard bench for version_info_tx
//
// Purpose:
//   DUT A (4 uptime bytes, 10-cycle second) is driven with requests and
//   randomized backpressure; a negedge monitor rebuilds frames and checks
//   them against a queue of expected frames produced by a frame model.
//   DUT B (1 uptime byte, 2-cycle second) covers saturation; DUT C
//   (no uptime bytes, 1-cycle second) covers the short frame.

module tb_version_info_tx;

  localparam logic [31:0] VER   = 32'h0000_0037;
  localparam logic [55:0] STAMP = 56'h2025_1105_194554;
  localparam int HZ_A = 10;
  localparam int UB_A = 4;
  localparam int FLEN_A = 14 + UB_A;
  localparam int HZ_B = 2;
  localparam int UB_B = 1;
  localparam int HZ_C = 1;
  localparam int UB_C = 0;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A
  logic        rst_n, req, tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;
  logic [31:0] up_a;

  // DUT B / C
  logic        rst_nb, req_b, req_c, rdy_bc;
  logic [7:0]  data_b, data_c;
  logic        valid_b, valid_c, busy_b, busy_c, done_b, done_c;
  logic [7:0]  up_b;
  logic [0:0]  up_c;

  version_info_tx #(
    .VERSION_WORD(VER), .BUILD_STAMP(STAMP), .SYNC_BYTE(8'hA5),
    .UPTIME_BYTES(UB_A), .CLK_HZ(HZ_A)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
    .uptime_sec(up_a)
  );

  version_info_tx #(
    .VERSION_WORD(VER), .BUILD_STAMP(STAMP), .SYNC_BYTE(8'hA5),
    .UPTIME_BYTES(UB_B), .CLK_HZ(HZ_B)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_nb), .req(req_b), .tx_data(data_b),
    .tx_valid(valid_b), .tx_ready(rdy_bc), .busy(busy_b), .done(done_b),
    .uptime_sec(up_b)
  );

  version_info_tx #(
    .VERSION_WORD(VER), .BUILD_STAMP(STAMP), .SYNC_BYTE(8'hA5),
    .UPTIME_BYTES(UB_C), .CLK_HZ(HZ_C)
  ) u_dut_c (
    .clk(clk), .rst_n(rst_nb), .req(req_c), .tx_data(data_c),
    .tx_valid(valid_c), .tx_ready(rdy_bc), .busy(busy_c), .done(done_c),
    .uptime_sec(up_c)
  );

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  logic [7:0] basic_tbl [18] = '{8'hA5, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h37,
                                 8'h20, 8'h25, 8'h11, 8'h05, 8'h19, 8'h45,
                                 8'h54, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAD};

  function automatic bq_t make_frame(int ub, longint unsigned snap);
    bq_t f;
    logic [31:0] v = VER;
    logic [55:0] s = STAMP;
    logic [7:0] sum = 8'h00;
    f.push_back(8'hA5);
    f.push_back(8'(11 + ub));
    for (int i = 3; i >= 0; i--) f.push_back(v[8*i +: 8]);
    for (int i = 6; i >= 0; i--) f.push_back(s[8*i +: 8]);
    for (int i = ub - 1; i >= 0; i--) f.push_back(8'(snap >> (8*i)));
    for (int i = 1; i < f.size(); i++) sum = sum + f[i];
    f.push_back(8'h00 - sum);
    return f;
  endfunction

  // Seconds after k clock edges out of reset, saturating at the counter width.
  function automatic longint unsigned up_model(longint k, int hz, int ub);
    longint unsigned v = longint'(k / hz);
    longint unsigned mx = (ub >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*ub)) - 1);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  longint cyc = 0;
  longint k_a = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) k_a = 0;
    else k_a++;
  end

  // Scoreboard: 0 = fixed basic table, 1 = model frame with live snapshot.
  int     exp_q[$];
  bit     req_cycle = 1'b0;
  bit     in_frame = 1'b0;
  bq_t    cur;
  logic [7:0] prev_data = 8'h00;
  bit     prev_stall = 1'b0;
  bit     done_exp = 1'b0;
  longint unsigned exp_snap = 0;
  int     frames_done = 0;
  int     done_count = 0;
  longint last_done_cyc = 0;
  longint gap_at_start = 0;
  longint start_cyc = 0;
  longint frame_cycles = 0;

  task automatic finish_frame();
    bq_t e;
    int  tag;
    in_frame     = 1'b0;
    frames_done++;
    done_exp     = 1'b1;
    frame_cycles = cyc - start_cyc + 1;
    check("frame_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      tag = exp_q.pop_front();
      if (tag == 0) begin
        for (int i = 0; i < 18; i++) e.push_back(basic_tbl[i]);
      end else begin
        e = make_frame(UB_A, exp_snap);
      end
      for (int i = 0; i < FLEN_A; i++) check($sformatf("a_byte%0d", i), cur[i], e[i]);
    end
  endtask

  // Monitor for DUT A
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_frame   = 1'b0;
      cur.delete();
      exp_q.delete();
      prev_stall = 1'b0;
      done_exp   = 1'b0;
    end else begin
      if (done || done_exp) check("done_pulse", done, done_exp);
      if (done) begin
        done_count++;
        last_done_cyc = cyc;
      end
      done_exp = 1'b0;
      if (!req_cycle) check("busy", busy, exp_q.size() > 0);
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
      end
      if (tx_valid) begin
        if (!in_frame) begin
          in_frame     = 1'b1;
          cur.delete();
          // Snapshot is the uptime during the IDLE cycle before SYNC shows.
          exp_snap     = up_model(k_a - 1, HZ_A, UB_A);
          gap_at_start = cyc - last_done_cyc;
          start_cyc    = cyc;
        end
        if (tx_ready) begin
          cur.push_back(tx_data);
          if (cur.size() == FLEN_A) finish_frame();
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (cyc % 7 == 0) check("uptime_a", up_a, up_model(k_a, HZ_A, UB_A));
    end
  end

  // Backpressure driver: 0 always ready, 1 random with 20-cycle stalls, 2 stalled
  int rdy_mode = 0;
  int stall_left = 0;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        2: tx_ready = 1'b0;
        default: begin
          if (stall_left > 0) begin
            stall_left--;
            tx_ready = 1'b0;
          end else if ($urandom_range(0, 29) == 0) begin
            stall_left = 19;
            tx_ready   = 1'b0;
          end else begin
            tx_ready = 1'($urandom_range(0, 1));
          end
        end
      endcase
    end
  end

  // At most one frame in flight plus one pending; a request in the idle
  // cycle that is already launching a pending frame is absorbed.
  task automatic pulse_req(input int tag);
    @(posedge clk);
    #1;
    req = 1'b1;
    req_cycle = 1'b1;
    if (exp_q.size() == 0 || (exp_q.size() == 1 && in_frame)) exp_q.push_back(tag);
    @(posedge clk);
    #1;
    req = 1'b0;
    req_cycle = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || in_frame) && n < budget);
    check("idle_reached", (exp_q.size() == 0 && !in_frame), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_bytes(input int nb, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_frame && cur.size() >= nb) && n < budget);
    check("bytes_reached", (in_frame && cur.size() >= nb), 1);
  endtask

  // ---------------------------------------------------------------------
  // DUT B / C stimulus and capture
  // ---------------------------------------------------------------------
  bq_t qb, qc;
  int  nd_b = 0, nd_c = 0;
  bit  bc_done = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst_nb) begin
      if (valid_b) qb.push_back(data_b);
      if (valid_c) qc.push_back(data_c);
      if (done_b) nd_b++;
      if (done_c) nd_c++;
    end
  end

  initial begin
    rst_nb = 1'b0;
    req_b  = 1'b0;
    req_c  = 1'b0;
    rdy_bc = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_nb = 1'b1;
    while (cyc < 10) @(posedge clk);
    #1 req_c = 1'b1;
    @(posedge clk);
    #1 req_c = 1'b0;
    while (cyc < 600) @(posedge clk);
    #1;
    check("b_uptime_600", up_b, 8'hFF);
    req_b = 1'b1;
    @(posedge clk);
    #1 req_b = 1'b0;
    while (cyc < 700) @(posedge clk);
    #1;
    check("b_uptime_700", up_b, 8'hFF);
    bc_done = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Main sequence for DUT A
  // ---------------------------------------------------------------------
  initial begin
    int f0, d0, n;
    bq_t e;
    rst_n = 1'b0;
    req   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_uptime", up_a, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic frame against the fixed byte table
    f0 = frames_done;
    d0 = done_count;
    pulse_req(0);
    wait_idle(200);
    check("basic_frames", frames_done - f0, 1);
    check("basic_dones", done_count - d0, 1);
    check("basic_cycles", frame_cycles, FLEN_A);

    // Random backpressure, random idle gaps, occasional queued request
    rdy_mode = 1;
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      pulse_req(1);
      if ($urandom_range(0, 1) == 1) begin
        wait_bytes($urandom_range(1, 15), 2000);
        pulse_req(1);
      end
      wait_idle(4000);
    end

    // Long stall inside the uptime bytes: snapshot must not move
    rdy_mode = 0;
    pulse_req(1);
    wait_bytes(14, 200);
    rdy_mode = 2;
    repeat (130) @(posedge clk);
    rdy_mode = 0;
    wait_idle(500);

    // Request queuing: byte 3 queues, byte 7 is dropped
    f0 = frames_done;
    pulse_req(1);
    wait_bytes(3, 200);
    pulse_req(1);
    wait_bytes(7, 200);
    pulse_req(1);
    wait_idle(500);
    check("queue_frames", frames_done - f0, 2);
    check("queue_gap_le2", (gap_at_start >= 1 && gap_at_start <= 2), 1);

    // Reset in the middle of a frame
    pulse_req(1);
    wait_bytes(6, 200);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_uptime", up_a, 0);
    check("midrst_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    f0 = frames_done;
    pulse_req(1);
    wait_idle(300);
    check("postrst_frames", frames_done - f0, 1);

    // Saturating and zero-uptime builds
    n = 0;
    while (!bc_done && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("bc_finished", bc_done, 1);
    repeat (5) @(negedge clk);
    e = make_frame(UB_B, up_model(1000, HZ_B, UB_B));
    check("b_len", qb.size(), 15);
    for (int i = 0; i < e.size() && i < qb.size(); i++) check($sformatf("b_byte%0d", i), qb[i], e[i]);
    e = make_frame(UB_C, 0);
    check("c_len", qc.size(), 14);
    for (int i = 0; i < e.size() && i < qc.size(); i++) check($sformatf("c_byte%0d", i), qc[i], e[i]);
    check("b_dones", nd_b, 1);
    check("c_dones", nd_c, 1);
    check("b_busy_end", busy_b, 0);
    check("c_busy_end", busy_c, 0);
    check("c_uptime_tied", up_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
